// File: rtl/fxp_add_arbiter_if.sv
// Request/response bundle between the shared fixed-point adder and its clients.
// The master side is the client/consumer environment; the slave side is the arbiter.
interface fxp_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WI   = 4,
  parameter int WF   = 4
);
  localparam int W   = WI + WF;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ovf;
  logic [15:0]       ovf_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, ovf_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, ovf_cnt
  );
endinterface

// File: rtl/fxp_add_arbiter.sv
// Round-robin arbiter sharing one signed Q(WI.WF) adder among NREQ requesters,
// with a single-entry registered result stage and a saturating overflow counter.
module fxp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int WI   = 4,
  parameter int WF   = 4,
  parameter int SAT  = 1
) (
  input logic              clk,
  input logic              rst,
  fxp_add_arbiter_if.slave bus
);
  localparam int W   = WI + WF;
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_sum_q;
  logic           rsp_ovf_q;
  logic [15:0]    ovf_cnt_q;

  logic           found;
  logic [IDW-1:0] win_id;
  logic           can_accept;
  logic           xfer;
  logic [NREQ-1:0] ready_vec;
  logic [W-1:0]   a_op;
  logic [W-1:0]   b_op;
  logic [W:0]     s_ext;
  logic           ovf;
  logic [W-1:0]   sat_val;
  logic [W-1:0]   sum_res;

  // (base + off) mod NREQ without a divider; off is always < NREQ here
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NREQ) t = t - NREQ;
    return t[IDW-1:0];
  endfunction

  // Winner search: walk from lowest to highest priority so the last hit (offset 0 side) wins
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(ptr, k)]) begin
        found  = 1'b1;
        win_id = rr_idx(ptr, k);
      end
    end
  end

  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign xfer       = found && can_accept && !rst;

  // One-hot grant to the winner, suppressed while the output stage is blocked or in reset
  always_comb begin
    ready_vec = '0;
    if (xfer) ready_vec[win_id] = 1'b1;
  end

  assign a_op    = bus.req_a[int'(win_id)*W +: W];
  assign b_op    = bus.req_b[int'(win_id)*W +: W];
  assign s_ext   = {a_op[W-1], a_op} + {b_op[W-1], b_op};
  assign ovf     = s_ext[W] ^ s_ext[W-1];
  assign sat_val = s_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign sum_res = (ovf && SAT != 0) ? sat_val : s_ext[W-1:0];

  // Result register, round-robin pointer and overflow counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready && rsp_ovf_q && ovf_cnt_q != 16'hFFFF)
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (xfer) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= win_id;
        rsp_sum_q   <= sum_res;
        rsp_ovf_q   <= ovf;
        ptr         <= rr_idx(win_id, 1);
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Directed bench for fxp_add_arbiter: a cycle model with a result scoreboard
// plus explicit checks of the worked examples; a second instance covers wrap mode.
module tb_fxp_add_arbiter;
  localparam int NREQ = 4;
  localparam int WI   = 4;
  localparam int WF   = 4;
  localparam int W    = WI + WF;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         ovf;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fxp_add_arbiter_if #(.NREQ(NREQ), .WI(WI), .WF(WF)) if0 ();
  fxp_add_arbiter_if #(.NREQ(NREQ), .WI(WI), .WF(WF)) if1 ();

  fxp_add_arbiter #(.NREQ(NREQ), .WI(WI), .WF(WF), .SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(if0));
  fxp_add_arbiter #(.NREQ(NREQ), .WI(WI), .WF(WF), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(if1));

  int total  = 0;
  int passed = 0;

  rsp_t        sb[$];
  logic        m_full = 1'b0;
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = '0;

  int rr_seq[6] = '{0, 1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic rsp_t model_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    int av, bv, s;
    av = int'($signed(a));
    bv = int'($signed(b));
    s  = av + bv;
    r.id  = id[1:0];
    r.ovf = (s > MAXV) || (s < MINV);
    if (s > MAXV)      r.sum = 8'h7F;
    else if (s < MINV) r.sum = 8'h80;
    else               r.sum = s[W-1:0];
    return r;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    if0.req_a[i*W +: W] = a;
    if0.req_b[i*W +: W] = b;
  endtask

  // One clock: compare DUT against the model at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive the next inputs.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    logic            grant;
    int              win;
    rsp_t            r;
    @(negedge clk);
    exp_ready = '0;
    grant     = 1'b0;
    win       = 0;
    if (!rst && (!m_full || if0.rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!grant && if0.req_valid[i]) begin
          grant = 1'b1;
          win   = i;
        end
      end
      if (grant) exp_ready[win] = 1'b1;
    end
    check("req_ready", 32'(if0.req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(if0.rsp_valid), 32'(m_full));
    if (m_full && sb.size() > 0) begin
      check("rsp_id",  32'(if0.rsp_id),  32'(sb[0].id));
      check("rsp_sum", 32'(if0.rsp_sum), 32'(sb[0].sum));
      check("rsp_ovf", 32'(if0.rsp_ovf), 32'(sb[0].ovf));
    end
    check("ovf_cnt", 32'(if0.ovf_cnt), 32'(m_cnt));
    if (rst) begin
      sb.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = '0;
    end else begin
      if (m_full && if0.rsp_ready) begin
        r = sb.pop_front();
        if (r.ovf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_full = 1'b0;
      end
      if (grant) begin
        sb.push_back(model_add(win, if0.req_a[win*W +: W], if0.req_b[win*W +: W]));
        m_full = 1'b1;
        m_ptr  = (win + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    if0.req_valid = '1;
    if0.req_a     = '0;
    if0.req_b     = '0;
    if0.rsp_ready = 1'b1;
    if1.req_valid = '0;
    if1.req_a     = '0;
    if1.req_b     = '0;
    if1.rsp_ready = 1'b1;

    // reset: outputs cleared and no grant while rst is high even with all requesters valid
    repeat (2) @(posedge clk);
    #1;
    step();
    check("reset rsp_valid", 32'(if0.rsp_valid), 32'h0);
    check("reset rsp_id",    32'(if0.rsp_id),    32'h0);
    check("reset rsp_sum",   32'(if0.rsp_sum),   32'h0);
    check("reset ovf_cnt",   32'(if0.ovf_cnt),   32'h0);
    rst = 1'b0;

    // basic add on requester 2
    if0.req_valid = 4'b0100;
    set_op(2, 8'h28, 8'h14);
    step();
    check("basic rsp_valid", 32'(if0.rsp_valid), 32'h1);
    check("basic rsp_id",    32'(if0.rsp_id),    32'h2);
    check("basic rsp_sum",   32'(if0.rsp_sum),   32'h3C);
    check("basic rsp_ovf",   32'(if0.rsp_ovf),   32'h0);
    if0.req_valid = '0;
    step();

    // positive overflow: saturating instance and wrapping instance side by side
    if0.req_valid = 4'b0001;
    set_op(0, 8'h70, 8'h20);
    if1.req_valid = 4'b0001;
    if1.req_a[0 +: W] = 8'h70;
    if1.req_b[0 +: W] = 8'h20;
    step();
    check("sat pos sum",  32'(if0.rsp_sum), 32'h7F);
    check("sat pos ovf",  32'(if0.rsp_ovf), 32'h1);
    check("wrap valid",   32'(if1.rsp_valid), 32'h1);
    check("wrap sum",     32'(if1.rsp_sum), 32'h90);
    check("wrap ovf",     32'(if1.rsp_ovf), 32'h1);
    if0.req_valid = '0;
    if1.req_valid = '0;
    step();

    // negative overflow saturates to min
    if0.req_valid = 4'b0001;
    set_op(0, 8'h80, 8'hF0);
    step();
    check("sat neg sum", 32'(if0.rsp_sum), 32'h80);
    check("sat neg ovf", 32'(if0.rsp_ovf), 32'h1);
    if0.req_valid = '0;
    step();
    check("ovf_cnt two", 32'(if0.ovf_cnt), 32'h2);

    // steer the pointer to 0 via a lone grant to requester 3, then all requesters valid
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(8'h10 * i + 1), 8'h08);
    if0.req_valid = 4'b1000;
    step();
    if0.req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr id", 32'(if0.rsp_id), 32'(rr_seq[i]));
      check("rr onehot", 32'($onehot(if0.req_ready)), 32'h1);
    end

    // backpressure on the id 1 result; operand change during the stall is legal
    if0.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_op(2, 8'h33, 8'h08);
      step();
      check("stall id",    32'(if0.rsp_id),    32'h1);
      check("stall valid", 32'(if0.rsp_valid), 32'h1);
      check("stall ready", 32'(if0.req_ready), 32'h0);
    end
    if0.rsp_ready = 1'b1;
    step();
    check("release valid", 32'(if0.rsp_valid), 32'h1);
    check("release id",    32'(if0.rsp_id),    32'h2);
    check("release sum",   32'(if0.rsp_sum),   32'h3B);

    // third accepted overflow
    if0.req_valid = 4'b0001;
    set_op(0, 8'h70, 8'h20);
    step();
    if0.req_valid = '0;
    step();
    check("ovf_cnt three", 32'(if0.ovf_cnt), 32'h3);

    // overflowing result left pending with ptr at 3, then discarded by reset
    if0.req_valid = 4'b0100;
    set_op(2, 8'h70, 8'h20);
    if0.rsp_ready = 1'b0;
    step();
    if0.req_valid = '0;
    step();
    check("pending valid", 32'(if0.rsp_valid), 32'h1);
    check("pending ovf",   32'(if0.rsp_ovf),   32'h1);
    check("pending cnt",   32'(if0.ovf_cnt),   32'h3);
    rst = 1'b1;
    if0.req_valid = 4'b0110;
    step();
    check("post rst valid", 32'(if0.rsp_valid), 32'h0);
    check("post rst cnt",   32'(if0.ovf_cnt),   32'h0);
    rst = 1'b0;
    if0.rsp_ready = 1'b1;
    step();
    check("post rst grant id", 32'(if0.rsp_id), 32'h1);
    if0.req_valid = '0;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fxp_add_arbiter.md
# fxp_add_arbiter

Round-robin arbiter and sequencer that shares one signed fixed-point adder among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, adds the two operands in Q(WI.WF) two's-complement format, and registers the result into a single-entry output stage. That stage carries the requester ID, the sum and an overflow flag. The block sits between the datapath clients and the downstream result consumer, and replaces per-client adder instances.

## Interface
- `NREQ`, default 4: number of requesters; 2..8 supported.
- `WI`, default 4: integer bits, including the sign, of operands and result.
- `WF`, default 4: fraction bits of operands and result.
- `SAT`, default 1: 1 saturates on overflow; 0 wraps (keeps low WI+WF bits).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  operand pair valid, one bit per requester.
- `req_ready`  out  NREQ  grant/accept, one-hot or zero.
- `req_a`  in  NREQ*(WI+WF)  operand A; requester i at bits [i*(WI+WF) +: WI+WF].
- `req_b`  in  NREQ*(WI+WF)  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result register full.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  clog2(NREQ)  index of the requester that produced the result.
- `rsp_sum`  out  WI+WF  sum in Q(WI.WF).
- `rsp_ovf`  out  1  overflow occurred on this result.
- `ovf_cnt`  out  16  saturating count of overflowed results accepted since reset.

## Operation
- **Exact sum.** Sign-extend A and B to WI+WF+1 bits and add; the result `s` is exact.
- **Overflow.** `ovf = s[WI+WF] ^ s[WI+WF-1]`.
- **Result when `ovf=0`:** `s[WI+WF-1:0]`.
- **Result when `ovf=1` and SAT=1:**
  - `s[WI+WF]=0` gives max positive, `{0,1..1}`.
  - `s[WI+WF]=1` gives min negative, `{1,0..0}`.
- **Result when `ovf=1` and SAT=0:** `s[WI+WF-1:0]` (wrap).
- **Fraction handling:** none; operands and result share the format, so there is no truncation.
- **Output stage:** one state bit, EMPTY (`rsp_valid=0`) or FULL (`rsp_valid=1`).
  - `can_accept = !rsp_valid | rsp_ready`.
- **Arbitration:** a round-robin pointer `ptr` marks the highest-priority index.
  - Winner: the first i, searching ptr, ptr+1, … mod NREQ, with `req_valid[i]=1`.
  - `req_ready[winner] = can_accept`; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`.
- **Transfer:** occurs when `req_valid[i] & req_ready[i]`. On that edge:
  - result register loads `{i, sum, ovf}`;
  - `rsp_valid` goes to 1;
  - `ptr` goes to (i+1) mod NREQ.
- **Drain:** `rsp_valid & rsp_ready` with no new grant clears `rsp_valid`.
  - A drain and a grant in the same cycle reload the register; `rsp_valid` stays 1.
- **Pointer hold:** with no grant, `ptr` is unchanged.
- **Output stability:** while `rsp_valid=1` and `rsp_ready=0`, the outputs `rsp_id`, `rsp_sum` and `rsp_ovf` are held stable.
- **Overflow counter:** `ovf_cnt` increments when `rsp_valid & rsp_ready & rsp_ovf`, and holds at 0xFFFF.

## Timing
- **Reset values:** `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_ovf=0`, `ovf_cnt=0`, `ptr=0`.
- **During reset:** `req_ready=0` in any cycle where `rst=1`.
- **Latency:** 1 cycle. A request accepted at edge N appears with `rsp_valid=1` after edge N.
- **Throughput:** 1 result per cycle while `rsp_ready=1`, with zero bubbles.
- **Fairness:** with all requesters continuously valid and no backpressure, each is granted exactly once every NREQ cycles.
- **Backpressure:** when FULL and `rsp_ready=0`, all `req_ready=0`. Requesters must hold `req_valid` and their operands; the arbiter never drops a request.
- **Operand changes:** changing operands while valid without a grant is legal, but only the values sampled at the grant edge are used.
- **Reset mid-operation:** a pending result is discarded. `ptr` returns to 0 and no handshake completes on the reset edge.

## Test plan
- **Basic add.** WI=WF=4, SAT=1, requester 2 only: A=0x28 (2.5), B=0x14 (1.25).
  - Required: one cycle later `rsp_valid=1`, `rsp_id=2`, `rsp_sum=0x3C`, `rsp_ovf=0`.
- **Saturation.** A=0x70 (7.0), B=0x20 (2.0).
  - SAT=1: `rsp_sum=0x7F`, `rsp_ovf=1`.
  - SAT=0: `rsp_sum=0x90`, `rsp_ovf=1`.
  - A=0x80, B=0xF0 with SAT=1: `rsp_sum=0x80`, `rsp_ovf=1`.
- **Round-robin.** NREQ=4, all `req_valid=1` continuously, `rsp_ready=1`.
  - Required: `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles, and `req_ready` one-hot each cycle.
- **Backpressure.** Result for id 1 pending and `rsp_ready=0` for 3 cycles.
  - Required: outputs unchanged and all `req_ready=0` during the stall.
  - Raise `rsp_ready`: the next grant loads on the same edge, and `rsp_valid` stays 1 with no gap.
- **Reset mid-flight.** Assert `rst` for 1 cycle while `rsp_valid=1`, `rsp_ovf=1`, `ptr=3`.
  - Required: next cycle `rsp_valid=0` and `ovf_cnt=0`.
  - The first grant after reset goes to the lowest valid index.
- **Counter.** Issue 3 overflowing results and accept them; also issue 1 overflowing result that is discarded by reset before acceptance.
  - Required: `ovf_cnt=3` before the reset, and `ovf_cnt=0` after it.
